// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_pkg
// Purpose  : Shared widths and types for the integer register file.
// Revision : 1.0 - initial release
// ============================================================================
package reg_file_pkg;
    localparam int XLEN      = 32;
    localparam int NREGS     = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      xlen_t;
endpackage : reg_file_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : Per-register valid (committed) flags with reserve/set/reset.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import reg_file_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  reg_idx_t         rd,
    input  logic             reserve,
    input  reg_idx_t         wreg0,
    input  logic             wen0,
    input  reg_idx_t         wreg1,
    input  logic             wen1,
    output logic [NREGS-1:0] valid
);

    logic [NREGS-1:0] r_valid;

    // Later assignments win: port 1 set, then port 0 set, then reserve clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_valid <= '1;
        end else begin
            if (wen1 && (wreg1 != '0)) r_valid[wreg1] <= 1'b1;
            if (wen0 && (wreg0 != '0)) r_valid[wreg0] <= 1'b1;
            if (reserve && (rd != '0)) r_valid[rd]    <= 1'b0;
        end
    end

    assign valid = r_valid;

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module   : reg_file
// Purpose  : 32x32 integer register file with scoreboard, two read ports,
//            two write ports. Option macro: REGFILE_BYPASS_EN (write-to-read
//            forwarding on both read ports).
// Revision : 1.0 - initial release
// ============================================================================
module reg_file
    import reg_file_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [REG_IDX_W-1:0] rs1,
    output logic                 rs1_valid,
    output logic [XLEN-1:0]      rs1_data,
    input  logic [REG_IDX_W-1:0] rs2,
    output logic                 rs2_valid,
    output logic [XLEN-1:0]      rs2_data,
    input  logic [REG_IDX_W-1:0] rd,
    input  logic                 reserve,
    input  logic [REG_IDX_W-1:0] wreg0,
    input  logic [XLEN-1:0]      wdata0,
    input  logic                 wen0,
    input  logic [REG_IDX_W-1:0] wreg1,
    input  logic [XLEN-1:0]      wdata1,
    input  logic                 wen1
);

    xlen_t            r_regs [NREGS];
    logic [NREGS-1:0] w_valid_vec;

    regfile_scoreboard u_scoreboard (
        .clk     (clk),
        .reset_n (reset_n),
        .rd      (rd),
        .reserve (reserve),
        .wreg0   (wreg0),
        .wen0    (wen0),
        .wreg1   (wreg1),
        .wen1    (wen1),
        .valid   (w_valid_vec)
    );

    // Port 0 is written last so it wins a same-register conflict.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (wen1 && (wreg1 != '0)) r_regs[wreg1] <= wdata1;
            if (wen0 && (wreg0 != '0)) r_regs[wreg0] <= wdata0;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_rd_port
        reg_idx_t w_idx;
        xlen_t    w_data;
        logic     w_valid;

        assign w_idx = (p == 0) ? rs1 : rs2;

        always_comb begin
            w_data  = r_regs[w_idx];
            w_valid = w_valid_vec[w_idx];
`ifdef REGFILE_BYPASS_EN
            if (wen1 && (wreg1 == w_idx)) begin
                w_data  = wdata1;
                w_valid = 1'b1;
            end
            if (wen0 && (wreg0 == w_idx)) begin
                w_data  = wdata0;
                w_valid = 1'b1;
            end
`endif
            if (w_idx == '0) begin
                w_data  = '0;
                w_valid = 1'b1;
            end
        end
    end

    assign rs1_data  = g_rd_port[0].w_data;
    assign rs1_valid = g_rd_port[0].w_valid;
    assign rs2_data  = g_rd_port[1].w_data;
    assign rs2_valid = g_rd_port[1].w_valid;

endmodule : reg_file
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file
// Purpose  : Self-checking bench for reg_file: directed scenarios plus random
//            traffic against an array-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  rs1, rs2, rd, wreg0, wreg1;
    logic        rs1_valid, rs2_valid, reserve, wen0, wen1;
    logic [31:0] rs1_data, rs2_data, wdata0, wdata1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_data  [32];
    logic        m_valid [32];

    reg_file dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rs1       (rs1),
        .rs1_valid (rs1_valid),
        .rs1_data  (rs1_data),
        .rs2       (rs2),
        .rs2_valid (rs2_valid),
        .rs2_data  (rs2_data),
        .rd        (rd),
        .reserve   (reserve),
        .wreg0     (wreg0),
        .wdata0    (wdata0),
        .wen0      (wen0),
        .wreg1     (wreg1),
        .wdata1    (wdata1),
        .wen1      (wen1)
    );

    always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // Expected read value: stored state, optionally overridden by a write this cycle.
    function automatic void exp_read(input logic [4:0] idx, output logic [31:0] d,
                                     output logic v);
        d = m_data[idx];
        v = m_valid[idx];
        if (BYP && idx != 0) begin
            if (wen0 && wreg0 == idx) begin
                d = wdata0; v = 1'b1;
            end else if (wen1 && wreg1 == idx) begin
                d = wdata1; v = 1'b1;
            end
        end
        if (idx == 0) begin
            d = 32'h0; v = 1'b1;
        end
    endfunction

    task automatic idle();
        reset_n = 1'b1; reserve = 1'b0; wen0 = 1'b0; wen1 = 1'b0;
        rd = 0; wreg0 = 0; wreg1 = 0; wdata0 = 0; wdata1 = 0;
    endtask

    // Advance one clock edge and apply that edge's effect to the model.
    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 32; i++) begin
            if (!reset_n) begin
                m_data[i]  = 32'h0;
                m_valid[i] = 1'b1;
            end else if (i != 0) begin
                if (wen0 && wreg0 == i) begin
                    m_data[i] = wdata0; m_valid[i] = 1'b1;
                end else if (wen1 && wreg1 == i) begin
                    m_data[i] = wdata1; m_valid[i] = 1'b1;
                end
                if (reserve && rd == i) m_valid[i] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        rs1 = 5; rs2 = 31;
        #2;
        n_checks++; if (rs1_data !== 32'h0) $display("FAIL reset_x5_data got %h exp 0", rs1_data); else n_pass++;
        n_checks++; if (rs1_valid !== 1'b1) $display("FAIL reset_x5_valid got %b exp 1", rs1_valid); else n_pass++;
        n_checks++; if (rs2_data !== 32'h0) $display("FAIL reset_x31_data got %h exp 0", rs2_data); else n_pass++;
        n_checks++; if (rs2_valid !== 1'b1) $display("FAIL reset_x31_valid got %b exp 1", rs2_valid); else n_pass++;
    endtask

    task automatic test_reserve_write();
        idle();
        rd = 7; reserve = 1'b1; rs1 = 7;
        #2;
        n_checks++; if (rs1_valid !== 1'b1) $display("FAIL own_reserve_valid got %b exp 1", rs1_valid); else n_pass++;
        step();
        idle();
        #2;
        n_checks++; if (rs1_valid !== 1'b0) $display("FAIL reserved_valid got %b exp 0", rs1_valid); else n_pass++;
        wen1 = 1'b1; wreg1 = 7; wdata1 = 32'hDEADBEEF;
        #2;
        n_checks++; if (rs1_valid !== BYP) $display("FAIL wr_cycle_valid got %b exp %b", rs1_valid, BYP); else n_pass++;
        if (BYP) begin
            n_checks++; if (rs1_data !== 32'hDEADBEEF) $display("FAIL bypass_data got %h exp deadbeef", rs1_data); else n_pass++;
        end
        step();
        idle();
        #2;
        n_checks++; if (rs1_valid !== 1'b1) $display("FAIL written_valid got %b exp 1", rs1_valid); else n_pass++;
        n_checks++; if (rs1_data !== 32'hDEADBEEF) $display("FAIL written_data got %h exp deadbeef", rs1_data); else n_pass++;
    endtask

    task automatic test_x0();
        idle();
        rd = 0; reserve = 1'b1; wen0 = 1'b1; wreg0 = 0; wdata0 = 32'h1234; rs2 = 0;
        #2;
        n_checks++; if (rs2_data !== 32'h0 || rs2_valid !== 1'b1) $display("FAIL x0_same_cycle got %h/%b exp 0/1", rs2_data, rs2_valid); else n_pass++;
        step();
        idle();
        #2;
        n_checks++; if (rs2_data !== 32'h0) $display("FAIL x0_data got %h exp 0", rs2_data); else n_pass++;
        n_checks++; if (rs2_valid !== 1'b1) $display("FAIL x0_valid got %b exp 1", rs2_valid); else n_pass++;
    endtask

    task automatic test_dual_write();
        idle();
        wen0 = 1'b1; wreg0 = 3; wdata0 = 32'h11;
        wen1 = 1'b1; wreg1 = 3; wdata1 = 32'h22;
        rs1 = 3;
        #2;
        n_checks++;
        if (rs1_data !== (BYP ? 32'h11 : 32'h0) || rs1_valid !== 1'b1)
            $display("FAIL dual_same_cycle got %h/%b exp %h/1", rs1_data, rs1_valid, BYP ? 32'h11 : 32'h0);
        else n_pass++;
        step();
        idle();
        #2;
        n_checks++; if (rs1_data !== 32'h11) $display("FAIL dual_data got %h exp 11", rs1_data); else n_pass++;
        n_checks++; if (rs1_valid !== 1'b1) $display("FAIL dual_valid got %b exp 1", rs1_valid); else n_pass++;
    endtask

    task automatic test_collision();
        idle();
        rd = 9; reserve = 1'b1; wen0 = 1'b1; wreg0 = 9; wdata0 = 32'h55; rs2 = 9;
        step();
        idle();
        #2;
        n_checks++; if (rs2_data !== 32'h55) $display("FAIL collide_data got %h exp 55", rs2_data); else n_pass++;
        n_checks++; if (rs2_valid !== 1'b0) $display("FAIL collide_valid got %b exp 0", rs2_valid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        idle();
        rd = 4; reserve = 1'b1; wen0 = 1'b1; wreg0 = 6; wdata0 = 32'hAA;
        step();
        idle();
        rs1 = 4; rs2 = 6;
        #2;
        n_checks++; if (rs1_valid !== 1'b0) $display("FAIL mid_x4_pending got %b exp 0", rs1_valid); else n_pass++;
        n_checks++; if (rs2_data !== 32'hAA) $display("FAIL mid_x6_data got %h exp aa", rs2_data); else n_pass++;
        reset_n = 1'b0;
        step();
        idle();
        #2;
        n_checks++; if (rs1_valid !== 1'b1) $display("FAIL mid_reset_x4_valid got %b exp 1", rs1_valid); else n_pass++;
        n_checks++; if (rs2_data !== 32'h0) $display("FAIL mid_reset_x6_data got %h exp 0", rs2_data); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] ed1, ed2;
        logic        ev1, ev2;
        for (int c = 0; c < 400; c++) begin
            reset_n = ($urandom_range(0, 59) != 0);
            reserve = ($urandom_range(0, 2) == 0);
            wen0    = ($urandom_range(0, 2) == 0);
            wen1    = ($urandom_range(0, 2) == 0);
            rd      = 5'($urandom_range(0, 7));
            wreg0   = 5'($urandom_range(0, 7));
            wreg1   = 5'($urandom_range(0, 7));
            rs1     = 5'($urandom_range(0, 7));
            rs2     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            wdata0  = $urandom;
            wdata1  = $urandom;
            #2;
            exp_read(rs1, ed1, ev1);
            exp_read(rs2, ed2, ev2);
            n_checks++;
            if (rs1_data !== ed1 || rs1_valid !== ev1)
                $display("FAIL rand_rs1 cyc %0d x%0d got %h/%b exp %h/%b", c, rs1, rs1_data, rs1_valid, ed1, ev1);
            else n_pass++;
            n_checks++;
            if (rs2_data !== ed2 || rs2_valid !== ev2)
                $display("FAIL rand_rs2 cyc %0d x%0d got %h/%b exp %h/%b", c, rs2, rs2_data, rs2_valid, ed2, ev2);
            else n_pass++;
            step();
        end
        idle();
    endtask

    initial begin
        idle();
        rs1 = 0; rs2 = 0;
        for (int i = 0; i < 32; i++) begin
            m_data[i] = 32'h0; m_valid[i] = 1'b1;
        end
        @(negedge clk);
        test_reset();
        test_reserve_write();
        test_x0();
        test_dual_write();
        test_collision();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_reg_file
`default_nettype wire

// File: doc/reg_file.md
# reg_file

Integer register file with per-register scoreboard for the in-order RISC-V pipeline. It sits in the decode stage. It provides two combinational read ports with per-operand availability flags, a reservation input that marks a destination register pending, and two write ports: mem-stage results and writeback results. Decode stalls on any source operand whose valid flag is low.

## Interface
- Parameters: none. Widths are fixed at XLEN=32 and 32 registers, taken from the shared package.
- Reset and clock: reset reset_n, synchronous, active-low; clock clk.
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- rs1  input  5  read port 1 register index.
- rs1_valid  output  1  rs1 holds committed (non-pending) data.
- rs1_data  output  32  read port 1 data.
- rs2  input  5  read port 2 register index.
- rs2_valid  output  1  rs2 holds committed data.
- rs2_data  output  32  read port 2 data.
- rd  input  5  register to reserve.
- reserve  input  1  mark rd pending at this clock edge.
- wreg0  input  5  write port 0 index (mem stage).
- wdata0  input  32  write port 0 data.
- wen0  input  1  write port 0 enable.
- wreg1  input  5  write port 1 index (writeback stage).
- wdata1  input  32  write port 1 data.
- wen1  input  1  write port 1 enable.

## Operation
- State: 32×32-bit data array and a 32-bit valid vector.
- x0 always reads 0 with valid=1. Writes to x0 and reservations of x0 are ignored.
- Reads are combinational from state. With bypass enabled, a read is overridden by an enabled write port whose index matches the read index. In that case data = write data and valid = 1. Port 0 has priority over port 1.
- On a clock edge, wenN with wregN≠0 writes wdataN and sets valid[wregN].
- If both ports target the same register, port 0 data and port 0 valid set win.
- reserve with rd≠0 clears valid[rd].
- Reserve and write to the same register in the same cycle: data is written and valid ends 0 (reserve wins).
- The read flags use pre-edge state, so an instruction's own rd reservation never affects its own sources in the same cycle.
- No WAW tracking: a single valid bit per register.

## Timing
- Read path: zero latency (combinational).
- Write and reserve: take effect at the next rising edge. Without bypass, they are visible the cycle after.
- Reset (synchronous, any cycle, overrides write and reserve): all data = 0, all valid = 1. rs*_data and rs*_valid reflect this from the next cycle.
- Outputs have no registers of their own, so output reset values are fixed by array reset: data 0, valid 1.

## Configuration
- REGFILE_BYPASS_EN defined: same-cycle write-to-read forwarding on both read ports, as described above, including the valid flag.
- REGFILE_BYPASS_EN undefined: reads see only stored state. A register written this cycle reads old data and old valid until the next cycle.

## Structure
- Shared package holds XLEN=32, NREGS=32, REG_IDX_W=5, and the typedefs for register index and data word.
- One natural sub-module, regfile_scoreboard, holds the valid vector plus reserve/set/reset logic. The data array and read muxes stay in reg_file.

## Test plan
- Reset: hold reset_n=0 one cycle, then read x5/x31 -> data 0, valid 1.
- Reserve and write:
  - Reserve rd=7 -> next cycle rs1=7 gives valid 0.
  - wen1 wreg1=7 wdata1=0xDEADBEEF -> next cycle valid 1, data 0xDEADBEEF.
  - With REGFILE_BYPASS_EN, valid 1 and data 0xDEADBEEF in the write cycle itself.
- x0 handling: reserve rd=0 and write wreg0=0 data 0x1234 -> rs2=0 reads 0, valid 1.
- Dual-write conflict: wen0 wreg0=3 data 0x11 and wen1 wreg1=3 data 0x22 same cycle -> x3 = 0x11, valid 1. With bypass, rs1=3 shows 0x11 in that cycle.
- Reserve/write collision: reserve rd=9 while wen0 wreg0=9 data 0x55 -> x9 data 0x55, valid 0.
- Reset mid-operation: x4 reserved and x6 written with 0xAA, then reset_n=0 one cycle -> x4 valid 1, x6 data 0.
